// File: rtl/edge_detect_pkg.sv
// Shared definitions for the multi-channel edge detector.
//   mode_e      : per-channel edge selection (off / rising / falling / both)
//   DEF_*       : default parameter values used by edge_detect_multi
package edge_detect_pkg;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  localparam int DEF_N_CH            = 4;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 3;
  localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/edge_detect_ch.sv
// One edge-detector channel: synchroniser chain, debounce filter and
// registered, mode-gated edge pulses.
//   clk, reset_n : clock, synchronous active-low reset
//   i_a          : asynchronous level input
//   i_mode       : edge selection (mode_e encoding)
//   o_rise       : one-cycle pulse on an accepted, enabled 0->1 change
//   o_fall       : one-cycle pulse on an accepted, enabled 1->0 change
module edge_detect_ch
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_a,
  input  logic [1:0] i_mode,
  output logic       o_rise,
  output logic       o_fall
);

  localparam int BLANK = SYNC_STAGES + DEBOUNCE_CYCLES;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_filt;
  logic [7:0]             r_cnt;
  logic [8:0]             r_blank;
  logic                   r_rise;
  logic                   r_fall;

  mode_e w_mode;
  logic  w_sync;
  logic  w_blanking;
  logic  w_toggle;
  logic  w_en_rise;
  logic  w_en_fall;

  assign w_mode     = mode_e'(i_mode);
  assign w_en_rise  = (w_mode == MODE_RISE) || (w_mode == MODE_BOTH);
  assign w_en_fall  = (w_mode == MODE_FALL) || (w_mode == MODE_BOTH);
  assign w_sync     = r_sync[SYNC_STAGES-1];
  // After reset the filter follows the synchroniser until the chain and the
  // debounce window have flushed, so a level held through reset is no edge.
  assign w_blanking = (r_blank < 9'(BLANK));
  assign w_toggle   = (w_sync != r_filt) && (r_cnt == 8'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_filt  <= 1'b0;
      r_cnt   <= '0;
      r_blank <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_a};
      if (w_blanking) begin
        r_blank <= r_blank + 9'd1;
        r_filt  <= w_sync;
        r_cnt   <= '0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        // Pulse is registered on the same edge that flips the filtered level.
        r_rise <= w_toggle & ~r_filt & w_en_rise;
        r_fall <= w_toggle &  r_filt & w_en_fall;
        if (w_sync == r_filt) begin
          r_cnt <= '0;
        end else if (w_toggle) begin
          r_filt <= ~r_filt;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  end

  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel debounced edge detector with sticky status, interrupt and a
// saturating event counter.
//   clk, reset_n   : clock, synchronous active-low reset
//   a_i            : asynchronous level inputs, one per channel
//   mode_i         : 2 bits per channel (00 off, 01 rise, 10 fall, 11 both)
//   clear_i        : write-1-to-clear for status_o
//   cnt_clr_i      : synchronous clear of event_cnt_o
//   rising_edge_o  : per-channel rising-edge pulses
//   falling_edge_o : per-channel falling-edge pulses
//   status_o       : sticky per-channel event flags
//   irq_o          : OR of status_o, registered alongside it
//   event_cnt_o    : saturating count of all enabled pulses
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int N_CH            = DEF_N_CH,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_CH-1:0]   a_i,
  input  logic [2*N_CH-1:0] mode_i,
  input  logic [N_CH-1:0]   clear_i,
  input  logic              cnt_clr_i,
  output logic [N_CH-1:0]   rising_edge_o,
  output logic [N_CH-1:0]   falling_edge_o,
  output logic [N_CH-1:0]   status_o,
  output logic              irq_o,
  output logic [CNT_W-1:0]  event_cnt_o
);

  logic [N_CH-1:0]  r_status;
  logic             r_irq;
  logic [CNT_W-1:0] r_cnt;

  logic [N_CH-1:0]  w_pulse;
  logic [N_CH-1:0]  w_status_nxt;
  logic [6:0]       w_num;
  logic [CNT_W-1:0] w_cnt_nxt;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [6:0]       b);
    logic [CNT_W+6:0] s;
    s = {7'd0, a} + {{CNT_W{1'b0}}, b};
    if (s > {7'd0, {CNT_W{1'b1}}}) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    edge_detect_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .i_a    (a_i[g]),
      .i_mode (mode_i[2*g +: 2]),
      .o_rise (rising_edge_o[g]),
      .o_fall (falling_edge_o[g])
    );
  end

  // Channel pulses are already mode-gated, so any pulse is an enabled event.
  assign w_pulse      = rising_edge_o | falling_edge_o;
  assign w_status_nxt = (r_status & ~clear_i) | w_pulse;

  always_comb begin
    w_num = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_num = w_num + 7'(rising_edge_o[k]) + 7'(falling_edge_o[k]);
    end
  end

  assign w_cnt_nxt = cnt_clr_i ? sat_add('0, w_num) : sat_add(r_cnt, w_num);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_status <= '0;
      r_irq    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_status <= w_status_nxt;
      r_irq    <= |w_status_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign status_o    = r_status;
  assign irq_o       = r_irq;
  assign event_cnt_o = r_cnt;

endmodule

// File: tb/tb_edge_detect_multi.sv
module tb_edge_detect_multi;

  logic       clk;
  logic       reset_n;
  logic [3:0] a_i;
  logic [7:0] mode_i;
  logic [3:0] clear_i;
  logic       cnt_clr_i;
  logic [3:0] rising_edge_o;
  logic [3:0] falling_edge_o;
  logic [3:0] status_o;
  logic       irq_o;
  logic [7:0] event_cnt_o;

  edge_detect_multi #(
    .N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(3), .CNT_W(8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .a_i           (a_i),
    .mode_i        (mode_i),
    .clear_i       (clear_i),
    .cnt_clr_i     (cnt_clr_i),
    .rising_edge_o (rising_edge_o),
    .falling_edge_o(falling_edge_o),
    .status_o      (status_o),
    .irq_o         (irq_o),
    .event_cnt_o   (event_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int LAT = 5;  // SYNC_STAGES + DEBOUNCE_CYCLES

  typedef struct {
    int         cyc;
    logic [3:0] r;
    logic [3:0] f;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         exp_cnt = 0;
  logic [3:0] exp_status = 4'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      n_cmp++;
      if ({rising_edge_o, falling_edge_o} !== {mon_e.r, mon_e.f} || mon_e.cyc != cyc) begin
        n_bad++;
        $display("FAIL pulse @cyc %0d: rise=%b fall=%b, required rise=%b fall=%b @cyc %0d",
                 cyc, rising_edge_o, falling_edge_o, mon_e.r, mon_e.f, mon_e.cyc);
      end
    end else if ((rising_edge_o | falling_edge_o) !== 4'b0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_pulse @cyc %0d: rise=%b fall=%b, required 0000/0000",
               cyc, rising_edge_o, falling_edge_o);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Change the selected inputs and push the pulses the mode makes visible.
  task automatic toggle(input logic [3:0] m);
    logic [3:0] na, en_r, en_f, r, f;
    na = a_i ^ m;
    for (int i = 0; i < 4; i++) begin
      en_r[i] = mode_i[2*i];
      en_f[i] = mode_i[2*i+1];
    end
    r = m & na & en_r;
    f = m & ~na & en_f;
    if ((r | f) != 4'b0) begin
      q.push_back('{cyc: cyc + LAT, r: r, f: f});
      exp_cnt = exp_cnt + $countones(r) + $countones(f);
      if (exp_cnt > 255) exp_cnt = 255;
      exp_status = exp_status | r | f;
    end
    a_i = na;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d pulses pending, required 0", q.size());
      q.delete();
    end
    tick(2);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; a_i = 4'b0001; mode_i = 8'hFF; clear_i = 4'b0; cnt_clr_i = 1'b0;
    tick(3);
    n_cmp++;
    if ({rising_edge_o, falling_edge_o, status_o, irq_o, event_cnt_o} !== 21'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: rise=%b fall=%b st=%b irq=%b cnt=%0d, required all 0",
               rising_edge_o, falling_edge_o, status_o, irq_o, event_cnt_o);
    end
    reset_n = 1'b1;
    tick(10);
    n_cmp++;
    if (status_o !== 4'b0 || irq_o !== 1'b0 || event_cnt_o !== 8'd0) begin
      n_bad++;
      $display("FAIL post_reset: st=%b irq=%b cnt=%0d, required 0/0/0", status_o, irq_o, event_cnt_o);
    end
  endtask

  task automatic test_single_rise();
    mode_i = 8'hFF;
    toggle(4'b0010);
    wait_drain();
    n_cmp++;
    if (status_o !== 4'b0010 || irq_o !== 1'b1 || event_cnt_o !== 8'd1) begin
      n_bad++;
      $display("FAIL single_rise: st=%b irq=%b cnt=%0d, required 0010/1/1", status_o, irq_o, event_cnt_o);
    end
  endtask

  task automatic test_glitch();
    mode_i = 8'hFF;
    a_i[2] = 1'b1;
    tick(2);
    a_i[2] = 1'b0;
    tick(12);
    n_cmp++;
    if (status_o !== 4'b0010 || event_cnt_o !== 8'd1) begin
      n_bad++;
      $display("FAIL glitch_2cyc: st=%b cnt=%0d, required 0010/1", status_o, event_cnt_o);
    end
    toggle(4'b0100);
    tick(3);
    toggle(4'b0100);
    wait_drain();
    n_cmp++;
    if (status_o !== 4'b0110 || event_cnt_o !== 8'd3) begin
      n_bad++;
      $display("FAIL pulse_3cyc: st=%b cnt=%0d, required 0110/3", status_o, event_cnt_o);
    end
  endtask

  task automatic test_simultaneous();
    mode_i = 8'h55;
    toggle(a_i);  // all to 0: falling edges only, none enabled
    tick(12);
    n_cmp++;
    if (event_cnt_o !== 8'd3) begin
      n_bad++;
      $display("FAIL fall_disabled: cnt=%0d, required 3", event_cnt_o);
    end
    toggle(4'b1111);
    wait_drain();
    n_cmp++;
    if (event_cnt_o !== 8'd7 || status_o !== 4'b1111) begin
      n_bad++;
      $display("FAIL all_rise: cnt=%0d st=%b, required 7/1111", event_cnt_o, status_o);
    end
    toggle(4'b1111);
    tick(12);
    n_cmp++;
    if (event_cnt_o !== 8'd7) begin
      n_bad++;
      $display("FAIL all_fall_mode01: cnt=%0d, required 7", event_cnt_o);
    end
  endtask

  task automatic test_saturate();
    int k;
    mode_i = 8'hFF;
    while (exp_cnt < 254) begin
      k = 254 - exp_cnt;
      if (k >= 4) toggle(4'b1111);
      else toggle(4'(4'b1111 >> (4 - k)));
      wait_drain();
    end
    n_cmp++;
    if (event_cnt_o !== 8'd254) begin
      n_bad++;
      $display("FAIL preload: cnt=%0d, required 254", event_cnt_o);
    end
    toggle(4'b1111);
    wait_drain();
    n_cmp++;
    if (event_cnt_o !== 8'd255) begin
      n_bad++;
      $display("FAIL saturate: cnt=%0d, required 255", event_cnt_o);
    end
    toggle(4'b1111);
    wait_drain();
    n_cmp++;
    if (event_cnt_o !== 8'd255) begin
      n_bad++;
      $display("FAIL saturate_hold: cnt=%0d, required 255", event_cnt_o);
    end
    toggle(4'b0011);
    tick(LAT);
    cnt_clr_i = 1'b1;
    tick(1);
    cnt_clr_i = 1'b0;
    n_cmp++;
    if (event_cnt_o !== 8'd2) begin
      n_bad++;
      $display("FAIL clr_with_pulses: cnt=%0d, required 2", event_cnt_o);
    end
    exp_cnt = 2;
    wait_drain();
  endtask

  task automatic test_status_clear();
    clear_i = 4'b1111;
    tick(1);
    clear_i = 4'b0;
    n_cmp++;
    if (status_o !== 4'b0 || irq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_all: st=%b irq=%b, required 0000/0", status_o, irq_o);
    end
    exp_status = 4'b0;
    toggle(4'b0010);
    tick(LAT);
    clear_i = 4'b0010;
    tick(1);
    clear_i = 4'b0;
    n_cmp++;
    if (status_o !== 4'b0010 || irq_o !== 1'b1) begin
      n_bad++;
      $display("FAIL set_beats_clear: st=%b irq=%b, required 0010/1", status_o, irq_o);
    end
    wait_drain();
    clear_i = 4'b0010;
    tick(1);
    clear_i = 4'b0;
    n_cmp++;
    if (status_o !== 4'b0 || irq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_ch1: st=%b irq=%b, required 0000/0", status_o, irq_o);
    end
    exp_status = 4'b0;
  endtask

  task automatic test_mode_off();
    logic [7:0] c0;
    c0 = event_cnt_o;
    mode_i = 8'h00;
    tick(2);
    toggle(4'b1000);
    tick(12);
    n_cmp++;
    if (event_cnt_o !== c0 || status_o !== 4'b0) begin
      n_bad++;
      $display("FAIL mode_off: cnt=%0d st=%b, required %0d/0000", event_cnt_o, status_o, c0);
    end
    mode_i = 8'hFF;
    tick(3);
    toggle(4'b1000);
    wait_drain();
    n_cmp++;
    if (event_cnt_o !== 8'(exp_cnt) || status_o !== 4'b1000) begin
      n_bad++;
      $display("FAIL mode_reenable: cnt=%0d st=%b, required %0d/1000", event_cnt_o, status_o, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_debounce();
    a_i = a_i ^ 4'b0001;  // pending change, discarded by reset
    tick(3);
    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(14);
    n_cmp++;
    if (event_cnt_o !== 8'd0 || status_o !== 4'b0 || irq_o !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: cnt=%0d st=%b irq=%b, required 0/0000/0", event_cnt_o, status_o, irq_o);
    end
    exp_cnt = 0;
    exp_status = 4'b0;
  endtask

  initial begin
    test_reset();
    test_single_rise();
    test_glitch();
    test_simultaneous();
    test_saturate();
    test_status_clear();
    test_mode_off();
    test_reset_mid_debounce();
    tick(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/edge_detect_multi.md
EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent input channels, 1..32.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per channel, 2..4.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 3: consecutive stable cycles required to accept a level change, 1..255; 1 means no filtering.
REQ-004 SHALL have parameter CNT_W, default 8: width of the event counter.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port a_i, input, N_CH bits: asynchronous level inputs.
REQ-008 SHALL have port mode_i, input, 2*N_CH bits: per-channel mode (00 off, 01 rising, 10 falling, 11 both).
REQ-009 SHALL have port clear_i, input, N_CH bits: write-1-to-clear for the sticky status bits.
REQ-010 SHALL have port cnt_clr_i, input, 1 bit: synchronous clear of the event counter.
REQ-011 SHALL have port rising_edge_o, output, N_CH bits: one-cycle pulse per accepted rising edge.
REQ-012 SHALL have port falling_edge_o, output, N_CH bits: one-cycle pulse per accepted falling edge.
REQ-013 SHALL have port status_o, output, N_CH bits: sticky per-channel event flags.
REQ-014 SHALL have port irq_o, output, 1 bit: OR of status_o, registered.
REQ-015 SHALL have port event_cnt_o, output, CNT_W bits: saturating total count of enabled events.

Function
REQ-016 Each channel SHALL pass a_i through a SYNC_STAGES flop chain before any other use.
REQ-017 Debounce counter behaviour per channel:
- If the synchroniser output differs from the filtered level filt_q, the counter SHALL increment.
- If they are equal, the counter SHALL return to 0.
- When the counter equals DEBOUNCE_CYCLES-1 and the inputs still differ, filt_q SHALL toggle and the counter SHALL clear.
REQ-018 A filt_q 0->1 transition SHALL raise rising_edge_o; a 1->0 transition SHALL raise falling_edge_o.
- Pulses are registered, exactly one cycle wide, and gated by the mode enables.
- Mode 00 SHALL suppress pulses but still track filt_q.
REQ-019 Latency: the pulse SHALL be high in the cycle after the (SYNC_STAGES+DEBOUNCE_CYCLES)-th rising clk edge, counting from the first edge that samples the new a_i level.
REQ-020 Input glitches stable for fewer than DEBOUNCE_CYCLES synchronised cycles SHALL produce no pulse and no change to filt_q.
REQ-021 status_o[i] SHALL set on any enabled pulse of channel i and clear on clear_i[i]; if set and clear coincide, set SHALL win.
REQ-022 event_cnt_o SHALL add the number of enabled pulses in each cycle (0..N_CH).
- It SHALL saturate at 2^CNT_W-1 and never wrap.
- If cnt_clr_i coincides with pulses, the counter SHALL load that cycle's pulse count.
REQ-023 irq_o SHALL equal the OR of the next-state status bits, registered, so it is coincident with status_o.
REQ-024 A mode_i change SHALL take effect on the next edge, with no pulse generated by the mode change itself.

Reset
REQ-025 While reset_n=0 at a clk edge, the following SHALL go to 0:
- synchroniser flops, filt_q, debounce counters
- all pulse outputs, status_o, irq_o, event_cnt_o
REQ-026 For SYNC_STAGES+DEBOUNCE_CYCLES cycles after reset_n rises, filt_q SHALL load the synchroniser output directly with all pulses suppressed, so an input held high through reset creates no edge.
REQ-027 Reset asserted mid-debounce SHALL discard the pending change; no pulse SHALL follow.

Structure
REQ-028 Package edge_detect_pkg SHALL hold the mode typedef (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) and the default parameter constants.
REQ-029 Per-channel logic (synchroniser, debounce, edge pulse) SHALL be a sub-module edge_detect_ch instantiated N_CH times by generate; status, irq and counter SHALL stay in the top module.

Verification (N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=3, CNT_W=8)
REQ-030 The bench SHALL hold a_i=4'b0001 during reset, release reset, and wait 10 cycles -> no pulses, status_o=0, event_cnt_o=0.
REQ-031 The bench SHALL drive a_i[1] 0->1 with mode 11 -> rising_edge_o[1] high for exactly 1 cycle, 5 edges after sampling; status_o[1]=1, irq_o=1, event_cnt_o=1.
REQ-032 The bench SHALL apply a 2-cycle high glitch on a_i[2] -> no pulse and no status change; a 3-cycle high pulse -> one rise and one fall pulse.
REQ-033 The bench SHALL toggle all 4 channels simultaneously with mode 01 on every channel, rising -> event_cnt_o +4 in one cycle; falling -> no pulses and no count change.
REQ-034 The bench SHALL preload event_cnt_o to 254 via events, then fire 4 simultaneous edges -> event_cnt_o=255 and holding; cnt_clr_i together with 2 pulses -> event_cnt_o=2.
REQ-035 The bench SHALL assert clear_i[1] in the same cycle as a new pulse on channel 1 -> status_o[1] stays 1; clear_i[1] alone -> status_o[1]=0 and irq_o=0.
